// File: rtl/ixc_readback_19_if.sv
// Host-side readback channel: capture request, observed bus and bit-serial
// valid/ready stream with busy/done status.
interface ixc_readback_19_if #(
   parameter int WIDTH = 19
);
   logic [WIDTH-1:0] R;
   logic             req;
   logic             busy;
   logic             sdo;
   logic             sdo_valid;
   logic             sdo_ready;
   logic             done;

   modport master (
      output R, req, sdo_ready,
      input  busy, sdo, sdo_valid, done
   );

   modport slave (
      input  R, req, sdo_ready,
      output busy, sdo, sdo_valid, done
   );
endinterface

// File: rtl/ixc_readback_19.sv
// Snapshot readback of a 19-bit bus, streamed LSB first over valid/ready.
// Optional trailing even-parity bit when IXC_READBACK_PARITY_EN is defined.
module ixc_readback_19 #(
   parameter int WIDTH = 19,
   parameter int CNT_W = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   ixc_readback_19_if.slave    bus
);

`ifdef IXC_READBACK_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PAR, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] shadow;
   logic [CNT_W-1:0] count;
   logic             busy;
   logic             sdo;
   logic             sdo_valid;
   logic             done;

   assign bus.busy      = busy;
   assign bus.sdo       = sdo;
   assign bus.sdo_valid = sdo_valid;
   assign bus.done      = done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         shadow    <= '0;
         count     <= '0;
         busy      <= 1'b0;
         sdo       <= 1'b0;
         sdo_valid <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req) begin
                  shadow    <= bus.R;
                  count     <= '0;
                  state     <= SHIFT;
                  busy      <= 1'b1;
                  sdo       <= bus.R[0];
                  sdo_valid <= 1'b1;
               end
            end
            SHIFT: begin
               // sdo_valid is always high here, so ready alone marks a transfer
               if (bus.sdo_ready) begin
                  if (count < LAST) begin
                     count <= count + 1'b1;
                     sdo   <= shadow[count + 1'b1];
                  end else begin
`ifdef IXC_READBACK_PARITY_EN
                     state <= PAR;
                     sdo   <= ^shadow;
`else
                     state     <= DONE;
                     sdo_valid <= 1'b0;
                     done      <= 1'b1;
`endif
                  end
               end
            end
`ifdef IXC_READBACK_PARITY_EN
            PAR: begin
               if (bus.sdo_ready) begin
                  state     <= DONE;
                  sdo_valid <= 1'b0;
                  done      <= 1'b1;
               end
            end
`endif
            DONE: begin
               // req here is deliberately dropped, not queued
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               sdo_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ixc_readback_19.sv
// Bench for ixc_readback_19: queue-based stream model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ixc_readback_19;
   localparam int WIDTH = 19;
`ifdef IXC_READBACK_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int NBITS = WIDTH + P;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   ixc_readback_19_if #(.WIDTH(WIDTH)) bus();

   ixc_readback_19 #(.WIDTH(WIDTH), .CNT_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a snapshot is a queue of bits still to deliver
   bit q[$];
   bit m_done = 1'b0;
   bit m_sdo  = 1'b0;
   bit nd;
   int cyc = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_done = 1'b0;
         m_sdo  = 1'b0;
      end else begin
         cyc++;
         nd = 1'b0;
         if (q.size() > 0) begin
            if (bus.sdo_ready) begin
               void'(q.pop_front());
               if (q.size() == 0) nd = 1'b1;
               else m_sdo = q[0];
            end
         end else if (!m_done && bus.req) begin
            for (int i = 0; i < WIDTH; i++) q.push_back(bus.R[i]);
            if (P == 1) q.push_back(^bus.R);
            m_sdo = q[0];
         end
         m_done = nd;
      end
   end

   always @(negedge clk) begin
      chk("sdo_valid", {31'd0, bus.sdo_valid}, {31'd0, q.size() > 0});
      chk("done", {31'd0, bus.done}, {31'd0, m_done});
      chk("busy", {31'd0, bus.busy}, {31'd0, (q.size() > 0) || m_done});
      chk("sdo", {31'd0, bus.sdo}, {31'd0, m_sdo});
   end

   // Per-stream recorder for the directed scenarios
   logic [31:0] rec = '0;
   int rec_n = 0;
   int busy_n = 0;
   int done_cnt = 0;
   int done_cyc = -1;
   int t0 = 0;

   always @(negedge clk) begin
      if (bus.sdo_valid && bus.sdo_ready && rec_n < 32) begin
         rec[rec_n] = bus.sdo;
         rec_n++;
      end
      if (bus.busy) busy_n++;
      if (bus.done) begin
         if (done_cnt == 0) done_cyc = cyc - t0 + 1;
         done_cnt++;
      end
   end

   task automatic capture(input logic [18:0] r);
      bus.R = r;
      bus.req = 1'b1;
      bus.sdo_ready = 1'b1;
      rec = '0;
      rec_n = 0;
      busy_n = 0;
      done_cnt = 0;
      done_cyc = -1;
      @(posedge clk);
      #1 t0 = cyc;
      #1 bus.req = 1'b0;
   endtask

   task automatic run(input int ss, input int sl, input int rq_cyc, input logic [18:0] r2);
      int k;
      logic hv;
      k = 1;
      hv = 1'b0;
      while (done_cnt == 0 && k < 80) begin
         bus.sdo_ready = !(k >= ss && k < ss + sl);
         bus.req = (k == rq_cyc);
         if (k == rq_cyc) bus.R = r2;
         if (k == ss) hv = bus.sdo;
         if (k > ss && k <= ss + sl)
            chk("stall_hold", {30'd0, bus.sdo_valid, bus.sdo}, {30'd0, 1'b1, hv});
         @(posedge clk);
         #2;
         k++;
      end
      bus.req = 1'b0;
      bus.sdo_ready = 1'b1;
      chk("done_timeout", {31'd0, done_cnt != 0}, 32'd1);
   endtask

   initial begin
      bus.R = '0;
      bus.req = 1'b0;
      bus.sdo_ready = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_valid", {31'd0, bus.sdo_valid}, 32'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #2;

      // Full-rate capture
      capture(19'h5A5A5);
      run(0, 0, 0, 19'h0);
      chk("full_bits", rec, 32'h5A5A5);
      chk("full_count", rec_n, NBITS);
      chk("full_done_cyc", done_cyc, 20 + P);
      chk("full_done_cnt", done_cnt, 1);
      chk("full_busy_cycles", busy_n, 20 + P);
      repeat (2) @(posedge clk);
      #2;

      // Backpressure after bit 4 is presented
      capture(19'h7FFFF);
      run(5, 3, 0, 19'h0);
      chk("bp_bits", rec, (P == 1) ? 32'hFFFFF : 32'h7FFFF);
      chk("bp_ones", $countones(rec), NBITS);
      chk("bp_done_cyc", done_cyc, 23 + P);
      repeat (2) @(posedge clk);
      #2;

      // Snapshot isolation with req while busy, then back-to-back capture
      capture(19'h00001);
      run(0, 0, 5, 19'h7FFFF);
      chk("iso_bits", rec, (P == 1) ? 32'h80001 : 32'h00001);
      chk("iso_done_cyc", done_cyc, 20 + P);
      chk("iso_done_cnt", done_cnt, 1);
      capture(19'h7FFFF);
      chk("iso_restart_valid", {31'd0, bus.sdo_valid}, 32'd1);
      run(0, 0, 0, 19'h0);
      chk("iso_second_bits", rec, (P == 1) ? 32'hFFFFF : 32'h7FFFF);
      chk("iso_second_done", done_cyc, 20 + P);
      repeat (2) @(posedge clk);
      #2;

      // Reset while bit 10 is valid
      capture(19'($urandom));
      repeat (10) begin
         @(posedge clk);
         #2;
      end
      #1 rst_n = 1'b0;
      bus.req = 1'b1;
      #1;
      chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("mid_rst_sdo", {31'd0, bus.sdo}, 32'd0);
      chk("mid_rst_valid", {31'd0, bus.sdo_valid}, 32'd0);
      chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
      repeat (3) begin
         @(posedge clk);
         #2 bus.req = ~bus.req;
      end
      bus.req = 1'b0;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      chk("mid_rst_no_done", done_cnt, 0);
      chk("mid_rst_idle", {31'd0, bus.sdo_valid}, 32'd0);
      capture(19'h2AAAA);
      run(0, 0, 0, 19'h0);
      chk("post_rst_bits", rec, (P == 1) ? 32'hAAAAA : 32'h2AAAA);
      chk("post_rst_done", done_cyc, 20 + P);

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         @(posedge clk);
         #2;
         bus.R = 19'($urandom);
         bus.req = ($urandom % 4) == 0;
         bus.sdo_ready = ($urandom % 4) != 0;
         if ($urandom % 700 == 0) begin
            #1 rst_n = 1'b0;
            #1 rst_n = 1'b1;
         end
      end
      @(posedge clk);
      #2;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/ixc_readback_19.md
Name: ixc_readback_19

Overview:
- Readback end of the 19-bit assign path.
- Snapshots a 19-bit bus on request and returns the snapshot to the host-side debug/emulation channel.
- Output is a bit-serial stream with valid/ready flow control.
- Sits beside ixc_assign instances in IXCOM_TEMP_LIBRARY so driven nets can be read back without widening the host channel.

Parameters:
- WIDTH, 19, width of the observed bus and of the snapshot register.
- CNT_W, 5, bit-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- R  input  WIDTH  observed bus (same net as the assign's driven side).
- req  input  1  capture request; sampled only in IDLE.
- busy  output  1  high from first SHIFT cycle through the DONE cycle.
- sdo  output  1  serial data, LSB first; registered.
- sdo_valid  output  1  sdo holds a valid bit; registered.
- sdo_ready  input  1  consumer accepts the bit when sdo_valid && sdo_ready at a clock edge.
- done  output  1  one-cycle pulse after the last bit is accepted.

Behaviour:
- Reset (rst_n low, async): state=IDLE; shadow=0; count=0.
  - busy=0, sdo=0, sdo_valid=0, done=0.
  - Reset mid-operation aborts immediately: no done pulse, and the partial stream is discarded.
- States: IDLE, SHIFT, PAR (only with the optional feature), DONE.
- IDLE, req=1 at an edge:
  - shadow<=R, count<=0, state<=SHIFT.
  - Next cycle: busy=1, sdo_valid=1, sdo=R[0] as sampled at that edge.
  - Capture latency is 1 cycle.
- SHIFT, transfer occurs (sdo_valid && sdo_ready):
  - If count<WIDTH-1: count<=count+1, and sdo updates to shadow[count+1] next cycle.
  - If count==WIDTH-1: state<=PAR if the feature is enabled, else DONE.
- SHIFT, no transfer (sdo_ready=0): sdo, sdo_valid and count hold. There is no timeout.
- DONE: sdo_valid=0, done=1 and busy=1 for exactly one cycle, then IDLE with busy=0.
- req outside IDLE is ignored and is not queued, including req in the DONE cycle.
- R changes after the capture edge have no effect on the stream.
- Full-rate stream: with req at edge 0 and sdo_ready held high:
  - bits 0..18 appear in cycles 1..19;
  - done in cycle 20;
  - the next req is accepted at edge 21.
- count never exceeds WIDTH-1 and never wraps. sdo stays at its last value when sdo_valid=0.

Optional Feature:
- Macro: IXC_READBACK_PARITY_EN.
- Defined:
  - After bit WIDTH-1 is accepted, enter PAR.
  - In PAR, drive sdo = even parity of shadow (XOR of all bits) with sdo_valid=1.
  - Accepting the parity bit goes to DONE. Total stream is WIDTH+1 bits and done shifts one cycle later.
- Not defined:
  - PAR state and parity logic are absent. The stream is exactly WIDTH bits.

Test Plan:
- Reset values: assert rst_n=0 mid-cycle with req toggling -> busy, sdo, sdo_valid and done all 0 immediately; after release, no activity until req.
- Full-rate capture: R=19'h5A5A5, req pulse at edge 0, sdo_ready=1 -> sdo_valid cycles 1..19 with sdo=1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1,1,0,1; done=1 in cycle 20 only; busy=1 in cycles 1..20.
- Backpressure: R=19'h7FFFF, sdo_ready low for 3 cycles after bit 4 is presented -> sdo/sdo_valid stable through the stall; 19 ones total; done delayed by exactly 3 cycles (cycle 23).
- Snapshot isolation and req-while-busy: capture R=19'h00001, then set R=19'h7FFFF and pulse req in cycle 5 -> stream is 1 followed by 18 zeros; no second stream; a req at edge 21 starts a new stream of 19 ones.
- Reset mid-shift: assert rst_n=0 while bit 10 is valid -> no done pulse; after release, a req at R=19'h2AAAA streams the correct bits from bit 0.
- Parity (IXC_READBACK_PARITY_EN defined):
  - R=19'h00001 -> 20 bits, the last being 1; done in cycle 21.
  - R=19'h5A5A5 -> parity bit 0.
